// File: rtl/multdiv_pkg.sv
// Shared types and defaults for the multi-cycle multiply/divide sequencer.
package multdiv_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN,
        DONE
    } state_t;

    localparam logic OP_MULT = 1'b0;
    localparam logic OP_DIV  = 1'b1;

    localparam int ITER_DEF  = 32;
    localparam int CNT_W_DEF = 6;

endpackage

// File: rtl/multdiv_step_counter.sv
// Iteration counter for the multdiv sequencer: up-count on en, synchronous clear on sclr.
module multdiv_step_counter
    import multdiv_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clock,
    input  logic             clr_n,
    input  logic             en,
    input  logic             sclr,
    output logic [CNT_W-1:0] count
);

    // Clear wins over enable so a restart always begins from zero.
    always_ff @(posedge clock or negedge clr_n) begin
        if (!clr_n) begin
            count <= '0;
        end else if (sclr) begin
            count <= '0;
        end else if (en) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/multdiv_ctrl.sv
// Sequencer for the multi-cycle multiply/divide datapath (IDLE/LOAD/RUN/DONE).
// Optional multiply early termination via the MULTDIV_EARLY_TERM_EN macro (adds early_done).
module multdiv_ctrl
    import multdiv_pkg::*;
#(
    parameter int ITER  = ITER_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clock,
    input  logic             clr_n,
    input  logic             ctrl_mult,
    input  logic             ctrl_div,
    input  logic             divisor_zero,
    output logic             load,
    output logic             step_en,
    output logic             step_op,
    output logic [CNT_W-1:0] count,
    output logic             busy,
    output logic             result_rdy,
    output logic             exception
`ifdef MULTDIV_EARLY_TERM_EN
    ,
    input  logic             early_done
`endif
);

    state_t state;
    state_t state_nxt;
    logic   op_q;
    logic   exc_q;
    logic   start;
    logic   start_op;
    logic   last_step;
    logic   early_stop;

    assign start     = ctrl_mult | ctrl_div;
    assign start_op  = ctrl_div & ~ctrl_mult;
    assign last_step = (count == CNT_W'(ITER - 1));
    assign step_op   = op_q;

`ifdef MULTDIV_EARLY_TERM_EN
    assign early_stop = early_done & (op_q == OP_MULT);
`else
    assign early_stop = 1'b0;
`endif

    always_ff @(posedge clock or negedge clr_n) begin
        if (!clr_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        load       = 1'b0;
        step_en    = 1'b0;
        busy       = 1'b0;
        result_rdy = 1'b0;
        exception  = 1'b0;

        case (state)
            IDLE: begin
                state_nxt = IDLE;
            end
            LOAD: begin
                load      = 1'b1;
                busy      = 1'b1;
                state_nxt = ((op_q == OP_DIV) && divisor_zero) ? DONE : RUN;
            end
            RUN: begin
                step_en = 1'b1;
                busy    = 1'b1;
                if (last_step || early_stop) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                result_rdy = 1'b1;
                exception  = exc_q;
                state_nxt  = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        // A new start pulse aborts whatever job is in flight.
        if (start) begin
            state_nxt = LOAD;
        end
    end

    // Divide-by-zero is decided in LOAD and held only until the DONE cycle reports it.
    always_ff @(posedge clock or negedge clr_n) begin
        if (!clr_n) begin
            op_q  <= OP_MULT;
            exc_q <= 1'b0;
        end else begin
            if (start) begin
                op_q <= start_op;
            end
            if (state == LOAD) begin
                exc_q <= (op_q == OP_DIV) & divisor_zero;
            end else if (state == DONE) begin
                exc_q <= 1'b0;
            end
        end
    end

    multdiv_step_counter #(
        .CNT_W (CNT_W)
    ) u_step_counter (
        .clock (clock),
        .clr_n (clr_n),
        .en    (step_en),
        .sclr  (load),
        .count (count)
    );

endmodule

// File: tb/tb_multdiv_ctrl.sv
// Scoreboard bench for multdiv_ctrl: expected completions are queued at each start pulse.
module tb_multdiv_ctrl;
    import multdiv_pkg::*;

    localparam int ITER  = 32;
    localparam int CNT_W = 6;

    logic             clock = 1'b0;
    logic             clr_n;
    logic             ctrl_mult;
    logic             ctrl_div;
    logic             divisor_zero;
    logic             early_done;
    logic             load;
    logic             step_en;
    logic             step_op;
    logic [CNT_W-1:0] count;
    logic             busy;
    logic             result_rdy;
    logic             exception;

    typedef struct {
        int   cyc;
        logic exc;
        int   cnt;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   cyc    = 0;
    int   n_chk  = 0;
    int   n_err  = 0;
    int   nsteps;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    multdiv_ctrl #(
        .ITER  (ITER),
        .CNT_W (CNT_W)
    ) dut (
        .clock        (clock),
        .clr_n        (clr_n),
        .ctrl_mult    (ctrl_mult),
        .ctrl_div     (ctrl_div),
        .divisor_zero (divisor_zero),
        .load         (load),
        .step_en      (step_en),
        .step_op      (step_op),
        .count        (count),
        .busy         (busy),
        .result_rdy   (result_rdy),
        .exception    (exception)
`ifdef MULTDIV_EARLY_TERM_EN
        ,
        .early_done   (early_done)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Drive a one-cycle start pulse from the current time and queue its completion.
    task automatic drive_pulse(input logic m, input logic d, input int lat,
                               input logic exc, input int cnt);
        exp_t e;
        ctrl_mult = m;
        ctrl_div  = d;
        e.cyc = cyc + lat;
        e.exc = exc;
        e.cnt = cnt;
        sb.push_back(e);
        @(posedge clock);
        #1;
        ctrl_mult = 1'b0;
        ctrl_div  = 1'b0;
    endtask

    task automatic wait_count(input int v, input string tag);
        int k;
        k = 0;
        while (count !== CNT_W'(v) && k < 100) begin
            @(negedge clock);
            k++;
        end
        if (count !== CNT_W'(v)) chk(tag, count, v);
    endtask

    always @(negedge clock) begin
        if (clr_n === 1'b1 && result_rdy === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_rdy", 1, 0);
            end else begin
                mon_e = sb.pop_front();
                chk("rdy_cycle", cyc, mon_e.cyc);
                chk("rdy_exc", exception, mon_e.exc);
                chk("rdy_count", count, mon_e.cnt);
            end
        end
        if (clr_n === 1'b1 && result_rdy !== 1'b1 && exception !== 1'b0) begin
            chk("exc_without_rdy", exception, 0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "simulation timeout");
    end

    initial begin
        clr_n        = 1'b0;
        ctrl_mult    = 1'b0;
        ctrl_div     = 1'b0;
        divisor_zero = 1'b0;
        early_done   = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_load", load, 0);
        chk("rst_step_en", step_en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rdy", result_rdy, 0);
        chk("rst_exc", exception, 0);
        chk("rst_count", count, 0);
        chk("rst_step_op", step_op, 0);
        clr_n = 1'b1;
        @(posedge clock);
        #1;

        // Full multiply, then a back-to-back restart in its DONE cycle
        drive_pulse(1'b1, 1'b0, ITER + 2, 1'b0, ITER);
        @(negedge clock);
        chk("mult_load", load, 1);
        chk("mult_busy_load", busy, 1);
        chk("mult_step_in_load", step_en, 0);
        chk("mult_op", step_op, 0);
        nsteps = 0;
        repeat (ITER) begin
            @(negedge clock);
            nsteps += int'(step_en);
        end
        chk("mult_steps", nsteps, ITER);
        @(negedge clock);
        chk("done_busy", busy, 0);
        chk("done_step_en", step_en, 0);
        drive_pulse(1'b1, 1'b0, ITER + 2, 1'b0, ITER);
        @(negedge clock);
        chk("b2b_load", load, 1);
        repeat (40) @(negedge clock);

        // Divide by zero
        @(posedge clock);
        #1;
        divisor_zero = 1'b1;
        drive_pulse(1'b0, 1'b1, 2, 1'b1, 0);
        @(negedge clock);
        chk("dz_load", load, 1);
        chk("dz_op", step_op, 1);
        chk("dz_step_load", step_en, 0);
        @(negedge clock);
        chk("dz_step_done", step_en, 0);
        chk("dz_busy_done", busy, 0);
        @(negedge clock);
        chk("dz_exc_cleared", exception, 0);
        chk("dz_idle_busy", busy, 0);
        divisor_zero = 1'b0;

        // Simultaneous pulses: multiply wins, so divisor_zero must be ignored
        @(posedge clock);
        #1;
        divisor_zero = 1'b1;
        drive_pulse(1'b1, 1'b1, ITER + 2, 1'b0, ITER);
        @(negedge clock);
        chk("both_load", load, 1);
        chk("both_op", step_op, 0);
        repeat (36) @(negedge clock);
        divisor_zero = 1'b0;

        // Restart with a divide at count 15
        @(posedge clock);
        #1;
        drive_pulse(1'b1, 1'b0, ITER + 2, 1'b0, ITER);
        @(negedge clock);
        wait_count(15, "wait_count15");
        void'(sb.pop_back());
        drive_pulse(1'b0, 1'b1, ITER + 2, 1'b0, ITER);
        @(negedge clock);
        chk("restart_load", load, 1);
        chk("restart_op", step_op, 1);
        @(negedge clock);
        chk("restart_count", count, 0);
        repeat (40) @(negedge clock);

        // Early termination of a multiply at count 7
        @(posedge clock);
        #1;
`ifdef MULTDIV_EARLY_TERM_EN
        drive_pulse(1'b1, 1'b0, 10, 1'b0, 8);
`else
        drive_pulse(1'b1, 1'b0, ITER + 2, 1'b0, ITER);
`endif
        @(negedge clock);
        wait_count(7, "wait_count7");
        early_done = 1'b1;
        @(posedge clock);
        #1;
        early_done = 1'b0;
        repeat (40) @(negedge clock);

        // Asynchronous reset in the middle of a divide
        @(posedge clock);
        #1;
        drive_pulse(1'b0, 1'b1, ITER + 2, 1'b0, ITER);
        @(negedge clock);
        wait_count(10, "wait_count10");
        clr_n = 1'b0;
        void'(sb.pop_back());
        #1;
        chk("arst_load", load, 0);
        chk("arst_step_en", step_en, 0);
        chk("arst_busy", busy, 0);
        chk("arst_rdy", result_rdy, 0);
        chk("arst_exc", exception, 0);
        chk("arst_count", count, 0);
        chk("arst_step_op", step_op, 0);
        @(posedge clock);
        #1;
        clr_n = 1'b1;
        repeat (40) @(negedge clock);
        chk("arst_idle_busy", busy, 0);

        chk("sb_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/multdiv_ctrl.md
# multdiv_ctrl

Sequencer for the multi-cycle multiply/divide unit. Accepts single-cycle mult/div start pulses and loads the operands. It steps the shift/add datapath exactly ITER times using an internal step counter, then pulses result-ready, with a divide-by-zero exception flag. It sits between the decode/stall logic and the multdiv datapath; a busy output drives the pipeline stall.

## Interface
- ITER, 32: iterations per operation; must be ≥ 2.
- CNT_W, 6: step counter width; must satisfy 2^CNT_W > ITER.
- clock  in  1  single clock; all state updates on the rising edge.
- clr_n  in  1  asynchronous, active-low reset.
- ctrl_mult  in  1  one-cycle start pulse for a multiply.
- ctrl_div  in  1  one-cycle start pulse for a divide.
- divisor_zero  in  1  from the datapath; sampled only in LOAD.
- load  out  1  latch operands and clear the datapath accumulator; asserted for the LOAD cycle only.
- step_en  out  1  perform one iteration this cycle.
- step_op  out  1  operation of the current job: 0 = mult, 1 = div. Held stable from LOAD through DONE.
- count  out  CNT_W  completed iterations of the current job.
- busy  out  1  high in LOAD and RUN.
- result_rdy  out  1  one-cycle completion pulse.
- exception  out  1  divide-by-zero flag; valid only while result_rdy is high, otherwise 0.
- early_done  in  1  present only with MULTDIV_EARLY_TERM_EN (see Configuration).

## Operation
- Reset (clr_n low, asynchronous): state = IDLE, count = 0, step_op = 0. load, step_en, busy, result_rdy and exception are all 0.
- States: IDLE, LOAD, RUN, DONE. Outputs are decoded from state (Moore). count is a registered output.
- IDLE:
  - ctrl_mult or ctrl_div → LOAD.
  - step_op captured: 1 if ctrl_div and not ctrl_mult, else 0.
  - Both pulses in the same cycle: mult wins.
- LOAD:
  - load = 1; count cleared to 0.
  - If step_op = 1 and divisor_zero = 1 → DONE with exception latched. No steps are issued.
  - Otherwise → RUN.
- RUN:
  - step_en = 1; count increments by 1 each cycle.
  - In the cycle count = ITER-1, the step is still issued, count becomes ITER, and the next state is DONE.
- DONE:
  - result_rdy = 1 and count = ITER (count = 0 on an exception).
  - exception = the latched flag, which is then cleared.
  - Next state: IDLE.
- Restart: a ctrl_mult or ctrl_div pulse in LOAD, RUN or DONE aborts the current job.
  - Next state is LOAD with the newly captured step_op.
  - A pulse in DONE still emits that cycle's result_rdy.
  - A pulse in LOAD or RUN means no result_rdy is ever emitted for the aborted job.
- count arithmetic: unsigned, never wraps within a job, since 2^CNT_W > ITER.

## Timing
- Start pulse in cycle 0 → LOAD in cycle 1 → RUN in cycles 2..ITER+1 → DONE/result_rdy in cycle ITER+2.
- Latency for the defaults: 34 cycles from the start pulse to result_rdy.
- Divide-by-zero: result_rdy with exception in cycle 2.
- busy is high in cycles 1..ITER+1 and low in the result_rdy cycle.
- Back-to-back: a start pulse in the DONE cycle gives LOAD in the next cycle, with no IDLE gap.
- Reset mid-job takes effect immediately and asynchronously. No result_rdy is produced for that job.

## Configuration
- MULTDIV_EARLY_TERM_EN defined:
  - The early_done input exists.
  - In RUN with step_op = 0, early_done = 1 forces DONE next. The current step is still issued and counted.
  - Divide is unaffected.
- MULTDIV_EARLY_TERM_EN undefined:
  - The port is absent.
  - Every non-exception job runs exactly ITER steps.

## Structure
- multdiv_pkg holds:
  - the state enum (IDLE, LOAD, RUN, DONE);
  - the op encoding (OP_MULT = 0, OP_DIV = 1);
  - default constants ITER_DEF = 32 and CNT_W_DEF = 6.
- One sub-module: multdiv_step_counter.
  - CNT_W-bit up-counter with enable and synchronous clear; asynchronous active-low reset.
  - Instantiated once, with en = step_en and sclr = load.

## Test plan
- Reset while in RUN (count = 10) → all outputs 0 and state IDLE immediately. No result_rdy follows.
- ctrl_mult pulse with ITER = 32 → load in cycle 1, step_en in cycles 2..33, result_rdy = 1 with exception = 0 and count = 32 in cycle 34.
- ctrl_div with divisor_zero = 1 → step_en never asserted; result_rdy = 1 and exception = 1 in cycle 2.
- ctrl_mult and ctrl_div in the same cycle → step_op = 0; full 32-step run.
- ctrl_div while count = 15 → load in the next cycle, count = 0, step_op = 1. Exactly one result_rdy, 34 cycles after the second pulse.
- With MULTDIV_EARLY_TERM_EN, a mult with early_done = 1 when count = 7 → count = 8 and result_rdy = 1 in the following cycle. Without the macro, the same stimulus gives a full 34-cycle latency.
